// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side fetch/data ports, external memory bus and stall vector of mem_bus_arbiter.
// master = the arbiter; slave = the pipeline/memory environment around it.
interface mem_bus_arbiter_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [5:0]  stall;

  modport master (
    input  stallreq_id, stallreq_ex, if_ce, if_addr, mem_ce, mem_we, mem_sel,
           mem_addr, mem_wdata, bus_rdata, bus_ack,
    output if_rdata, mem_rdata, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall
  );

  modport slave (
    output stallreq_id, stallreq_ex, if_ce, if_addr, mem_ce, mem_we, mem_sel,
           mem_addr, mem_wdata, bus_rdata, bus_ack,
    input  if_rdata, mem_rdata, bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
           bus_err, stall
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and data ports (MEM first) and builds the pipeline stall vector.
// Optional MEM_BUS_TIMEOUT_EN aborts a bus cycle after TIMEOUT_CYCLES without ack and pulses bus_err.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_MEM = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic        tmo, fin_if, fin_mem, stallreq_if, stallreq_mem;
  logic [31:0] fin_data;
  logic [5:0]  stall;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt;

  // Counter sits at zero in IDLE, so every grant starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo = (state_q != IDLE) && !bus.bus_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  assign fin_if   = (state_q == BUSY_IF)  && (bus.bus_ack || tmo);
  assign fin_mem  = (state_q == BUSY_MEM) && (bus.bus_ack || tmo);
  assign fin_data = tmo ? 32'h0 : bus.bus_rdata;

  assign stallreq_mem = bus.mem_ce && !mem_done_q && !fin_mem;
  assign stallreq_if  = bus.if_ce  && !if_done_q  && !fin_if;

  always_comb begin
    stall = 6'b000000;
    if (rst)                                stall = 6'b000000;
    else if (stallreq_mem)                  stall = 6'b011111;
    else if (bus.stallreq_ex)               stall = 6'b001111;
    else if (bus.stallreq_id || stallreq_if) stall = 6'b000111;
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    // A done flag lives until its consuming pipeline register advances.
    if_done_d   = stall[1] ? if_done_q  : 1'b0;
    mem_done_d  = stall[4] ? mem_done_q : 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_ce && !mem_done_q) begin
          state_d = BUSY_MEM;
          req_d   = 1'b1;
          we_d    = bus.mem_we;
          sel_d   = bus.mem_sel;
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
        end else if (bus.if_ce && !if_done_q) begin
          state_d = BUSY_IF;
          req_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'b1111;
          addr_d  = bus.if_addr;
          wdata_d = 32'h0;
        end
      end
      BUSY_IF: begin
        if (fin_if) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          err_d      = tmo;
          if_rdata_d = fin_data;
          if_done_d  = 1'b1;
        end
      end
      BUSY_MEM: begin
        if (fin_mem) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          err_d      = tmo;
          mem_done_d = 1'b1;
          if (!we_q) mem_rdata_d = fin_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  // Completing reads are forwarded in the ack cycle so the pipeline can advance immediately.
  assign bus.if_rdata  = (fin_if && !rst) ? fin_data : if_rdata_q;
  assign bus.mem_rdata = (fin_mem && !we_q && !rst) ? fin_data : mem_rdata_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_err   = err_q;
  assign bus.stall     = stall;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, load under EX stall, conflict, store, reset, optional timeout.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic overlap_seen = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if bif ();
  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bif));

  // A done flag must never be set while its own bus cycle is still open.
  always @(negedge clk) begin
    if (rst === 1'b0 && ((dut.state_q == 2'd2 && dut.mem_done_q === 1'b1) ||
                         (dut.state_q == 2'd1 && dut.if_done_q === 1'b1)))
      overlap_seen = 1'b1;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bif.stallreq_id = 0; bif.stallreq_ex = 0;
    bif.if_ce = 0; bif.if_addr = 0;
    bif.mem_ce = 0; bif.mem_we = 0; bif.mem_sel = 4'hF; bif.mem_addr = 0; bif.mem_wdata = 0;
    bif.bus_rdata = 0; bif.bus_ack = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1; bif.stallreq_id = 1; bif.if_ce = 1; bif.mem_ce = 1;
    cyc(); cyc(); #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_bus_req got %b want 0", bif.bus_req); end
    n_cmp++; if (bif.bus_we !== 1'b0) begin n_bad++; $display("FAIL rst_bus_we got %b want 0", bif.bus_we); end
    n_cmp++; if (bif.bus_sel !== 4'h0) begin n_bad++; $display("FAIL rst_bus_sel got %h want 0", bif.bus_sel); end
    n_cmp++; if (bif.bus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_bus_addr got %h want 0", bif.bus_addr); end
    n_cmp++; if (bif.bus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_bus_wdata got %h want 0", bif.bus_wdata); end
    n_cmp++; if (bif.bus_err !== 1'b0) begin n_bad++; $display("FAIL rst_bus_err got %b want 0", bif.bus_err); end
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL rst_stall got %b want 000000", bif.stall); end
    n_cmp++; if (bif.if_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_if_rdata got %h want 0", bif.if_rdata); end
    n_cmp++; if (bif.mem_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_rdata got %h want 0", bif.mem_rdata); end
    cyc(); rst = 0; idle_inputs(); #1;
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL idle_stall got %b want 000000", bif.stall); end
    cyc(); #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL idle_bus_req got %b want 0", bif.bus_req); end
  endtask

  task automatic test_single_fetch;
    cyc(); bif.if_ce = 1; bif.if_addr = 32'h100; #1;
    n_cmp++; if (bif.stall !== 6'b000111) begin n_bad++; $display("FAIL fetch_stall_c0 got %b want 000111", bif.stall); end
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_c0 got %b want 0", bif.bus_req); end
    cyc(); #1;
    n_cmp++; if (bif.bus_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req_c1 got %b want 1", bif.bus_req); end
    n_cmp++; if (bif.bus_addr !== 32'h100) begin n_bad++; $display("FAIL fetch_addr got %h want 00000100", bif.bus_addr); end
    n_cmp++; if (bif.bus_sel !== 4'hF || bif.bus_we !== 1'b0) begin n_bad++; $display("FAIL fetch_sel_we got %h/%b want f/0", bif.bus_sel, bif.bus_we); end
    n_cmp++; if (bif.stall !== 6'b000111) begin n_bad++; $display("FAIL fetch_stall_c1 got %b want 000111", bif.stall); end
    cyc(); #1;
    n_cmp++; if (bif.bus_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req_c2 got %b want 1", bif.bus_req); end
    n_cmp++; if (bif.stall !== 6'b000111) begin n_bad++; $display("FAIL fetch_stall_c2 got %b want 000111", bif.stall); end
    cyc(); bif.bus_ack = 1; bif.bus_rdata = 32'h3C011234; #1;
    n_cmp++; if (bif.bus_req !== 1'b1) begin n_bad++; $display("FAIL fetch_req_c3 got %b want 1", bif.bus_req); end
    n_cmp++; if (bif.if_rdata !== 32'h3C011234) begin n_bad++; $display("FAIL fetch_bypass got %h want 3c011234", bif.if_rdata); end
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL fetch_stall_ack got %b want 000000", bif.stall); end
    cyc(); bif.bus_ack = 0; bif.bus_rdata = 0; bif.if_ce = 0; #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL fetch_req_after got %b want 0", bif.bus_req); end
    n_cmp++; if (bif.if_rdata !== 32'h3C011234) begin n_bad++; $display("FAIL fetch_hold got %h want 3c011234", bif.if_rdata); end
    cyc();
  endtask

  task automatic test_load_ex_stall;
    cyc(); bif.mem_ce = 1; bif.mem_addr = 32'h80; bif.mem_we = 0; bif.mem_sel = 4'hF; #1;
    n_cmp++; if (bif.stall !== 6'b011111) begin n_bad++; $display("FAIL load_stall_c0 got %b want 011111", bif.stall); end
    cyc(); #1;
    n_cmp++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h80) begin n_bad++; $display("FAIL load_bus got req=%b addr=%h want 1/00000080", bif.bus_req, bif.bus_addr); end
    n_cmp++; if (bif.stall !== 6'b011111) begin n_bad++; $display("FAIL load_stall_c1 got %b want 011111", bif.stall); end
    cyc(); bif.bus_ack = 1; bif.bus_rdata = 32'hDEADBEEF; bif.stallreq_ex = 1; #1;
    n_cmp++; if (bif.mem_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_bypass got %h want deadbeef", bif.mem_rdata); end
    n_cmp++; if (bif.stall !== 6'b001111) begin n_bad++; $display("FAIL load_stall_ack got %b want 001111", bif.stall); end
    for (int i = 0; i < 2; i++) begin
      cyc(); bif.bus_ack = 0; bif.bus_rdata = 0; bif.mem_ce = 0; #1;
      n_cmp++; if (bif.stall !== 6'b001111) begin n_bad++; $display("FAIL load_ex_stall[%0d] got %b want 001111", i, bif.stall); end
      n_cmp++; if (bif.mem_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_hold[%0d] got %h want deadbeef", i, bif.mem_rdata); end
      n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL load_no_reissue[%0d] got %b want 0", i, bif.bus_req); end
    end
    cyc(); bif.stallreq_ex = 0; #1;
    n_cmp++; if (bif.stall !== 6'b0 || bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL load_release got stall=%b req=%b want 000000/0", bif.stall, bif.bus_req); end
    cyc();
  endtask

  task automatic test_conflict;
    cyc(); bif.if_ce = 1; bif.if_addr = 32'h200; bif.mem_ce = 1; bif.mem_addr = 32'h84; #1;
    n_cmp++; if (bif.stall !== 6'b011111) begin n_bad++; $display("FAIL conf_stall_c0 got %b want 011111", bif.stall); end
    cyc(); bif.bus_ack = 1; bif.bus_rdata = 32'h11112222; #1;
    n_cmp++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h84) begin n_bad++; $display("FAIL conf_mem_first got req=%b addr=%h want 1/00000084", bif.bus_req, bif.bus_addr); end
    n_cmp++; if (bif.mem_rdata !== 32'h11112222) begin n_bad++; $display("FAIL conf_mem_rdata got %h want 11112222", bif.mem_rdata); end
    n_cmp++; if (bif.stall !== 6'b000111) begin n_bad++; $display("FAIL conf_stall_ack got %b want 000111", bif.stall); end
    cyc(); bif.bus_ack = 0; bif.bus_rdata = 0; bif.mem_ce = 0; #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL conf_gap got %b want 0", bif.bus_req); end
    n_cmp++; if (bif.stall !== 6'b000111) begin n_bad++; $display("FAIL conf_stall_gap got %b want 000111", bif.stall); end
    cyc(); bif.bus_ack = 1; bif.bus_rdata = 32'h33334444; #1;
    n_cmp++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h200) begin n_bad++; $display("FAIL conf_if_second got req=%b addr=%h want 1/00000200", bif.bus_req, bif.bus_addr); end
    n_cmp++; if (bif.if_rdata !== 32'h33334444) begin n_bad++; $display("FAIL conf_if_rdata got %h want 33334444", bif.if_rdata); end
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL conf_stall_if_ack got %b want 000000", bif.stall); end
    cyc(); bif.bus_ack = 0; bif.bus_rdata = 0; bif.if_ce = 0; #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL conf_end got %b want 0", bif.bus_req); end
    cyc();
  endtask

  task automatic test_store;
    cyc(); bif.mem_ce = 1; bif.mem_we = 1; bif.mem_sel = 4'b0011; bif.mem_addr = 32'h90;
    bif.mem_wdata = 32'h0000ABCD; bif.bus_rdata = 32'hFFFF0000; #1;
    n_cmp++; if (bif.stall !== 6'b011111) begin n_bad++; $display("FAIL store_stall got %b want 011111", bif.stall); end
    for (int i = 0; i < 2; i++) begin
      cyc(); bif.bus_ack = (i == 1); #1;
      n_cmp++; if (bif.bus_req !== 1'b1 || bif.bus_we !== 1'b1 || bif.bus_sel !== 4'b0011 ||
                   bif.bus_wdata !== 32'h0000ABCD || bif.bus_addr !== 32'h90) begin
        n_bad++; $display("FAIL store_bus[%0d] got req=%b we=%b sel=%b wdata=%h addr=%h want 1/1/0011/0000abcd/00000090",
                          i, bif.bus_req, bif.bus_we, bif.bus_sel, bif.bus_wdata, bif.bus_addr);
      end
      n_cmp++; if (bif.mem_rdata !== 32'h11112222) begin n_bad++; $display("FAIL store_rdata[%0d] got %h want 11112222", i, bif.mem_rdata); end
    end
    cyc(); bif.bus_ack = 0; bif.mem_ce = 0; bif.mem_we = 0; bif.mem_sel = 4'hF; bif.mem_wdata = 0; bif.bus_rdata = 0; #1;
    n_cmp++; if (bif.bus_req !== 1'b0 || bif.mem_rdata !== 32'h11112222) begin n_bad++; $display("FAIL store_end got req=%b rdata=%h want 0/11112222", bif.bus_req, bif.mem_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid;
    cyc(); bif.mem_ce = 1; bif.mem_addr = 32'hA0; #1;
    cyc(); rst = 1; #1;
    n_cmp++; if (bif.bus_req !== 1'b1) begin n_bad++; $display("FAIL rmid_busy got %b want 1", bif.bus_req); end
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL rmid_stall_in_rst got %b want 000000", bif.stall); end
    cyc(); rst = 0; bif.mem_ce = 0; bif.bus_ack = 1; bif.bus_rdata = 32'h55555555; #1;
    n_cmp++; if (bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_req got %b want 0", bif.bus_req); end
    n_cmp++; if (bif.stall !== 6'b0) begin n_bad++; $display("FAIL rmid_stall got %b want 000000", bif.stall); end
    n_cmp++; if (bif.mem_rdata !== 32'h0 || bif.if_rdata !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata got %h/%h want 0/0", bif.mem_rdata, bif.if_rdata); end
    cyc(); bif.bus_ack = 0; bif.bus_rdata = 0; #1;
    n_cmp++; if (bif.mem_rdata !== 32'h0 || bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL rmid_late_ack got rdata=%h req=%b want 0/0", bif.mem_rdata, bif.bus_req); end
    n_cmp++; if (dut.mem_done_q !== 1'b0) begin n_bad++; $display("FAIL rmid_done got %b want 0", dut.mem_done_q); end
    cyc();
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout;
    cyc(); bif.mem_ce = 1; bif.mem_addr = 32'hB0; bif.mem_we = 0; #1;
    for (int i = 1; i <= 3; i++) begin
      cyc(); #1;
      n_cmp++; if (bif.bus_req !== 1'b1 || bif.bus_err !== 1'b0 || bif.stall !== 6'b011111) begin
        n_bad++; $display("FAIL tmo_wait[%0d] got req=%b err=%b stall=%b want 1/0/011111", i, bif.bus_req, bif.bus_err, bif.stall);
      end
    end
    cyc(); #1;
    n_cmp++; if (bif.stall !== 6'b0 || bif.mem_rdata !== 32'h0) begin n_bad++; $display("FAIL tmo_fire got stall=%b rdata=%h want 000000/0", bif.stall, bif.mem_rdata); end
    cyc(); bif.mem_ce = 0; #1;
    n_cmp++; if (bif.bus_err !== 1'b1 || bif.bus_req !== 1'b0) begin n_bad++; $display("FAIL tmo_err got err=%b req=%b want 1/0", bif.bus_err, bif.bus_req); end
    cyc(); #1;
    n_cmp++; if (bif.bus_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse got %b want 0", bif.bus_err); end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_load_ex_stall();
    test_conflict();
    test_store();
    test_reset_mid();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (overlap_seen !== 1'b0) begin n_bad++; $display("FAIL done_set_clear_overlap got %b want 0", overlap_seen); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port external memory bus between the instruction-fetch port (IF) and the data-memory port (MEM).
- Generates the pipeline stall vector stall[5:0] from its own wait states and from the ID and EX stall requests. This is the vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Holds each completed read word until the consuming pipeline register advances.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles without ack before a forced abort (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stallreq_id  in  1  stall request from decode
- stallreq_ex  in  1  stall request from execute (multi-cycle div/madd)
- if_ce  in  1  fetch request valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetched word
- mem_ce  in  1  data access valid
- mem_we  in  1  1 = write
- mem_sel  in  4  byte enables
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data
- bus_req  out  1  bus cycle active
- bus_we  out  1  bus write
- bus_sel  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  one-cycle completion pulse
- bus_err  out  1  timeout pulse (0 when the optional feature is off)
- stall  out  6  [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. While rst is high:
  - state returns to IDLE; if_done and mem_done clear.
  - bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err, if_rdata and mem_rdata registers all reset to 0.
  - stall reads 0.
- Reset mid-transaction: bus_req drops the next edge and any in-flight ack is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- IDLE grant rule: MEM has priority because it is the older instruction.
  - Grant MEM if mem_ce && !mem_done; otherwise grant IF if if_ce && !if_done.
  - On grant, register the bus outputs from the granted port: IF is always a read with sel=4'b1111.
  - bus_req rises on the next edge.
- BUSY_x: bus outputs are held stable until bus_ack is sampled high. No abort or preemption: a MEM request arriving during BUSY_IF waits.
- On ack:
  - The port's rdata register captures bus_rdata, unless it was a write.
  - The port's done flag sets; state returns to IDLE; bus_req falls on the same edge.
  - The earliest next grant is the following cycle, so one IDLE cycle separates transactions.
- Read-data bypass: during the ack cycle, the port's rdata output equals bus_rdata combinationally; otherwise it shows the held register.
- Stall requests (combinational):
  - stallreq_mem = mem_ce && !mem_done && !(BUSY_MEM && bus_ack).
  - stallreq_if = if_ce && !if_done && !(BUSY_IF && bus_ack).
- Stall vector, priority high to low:
  - stallreq_mem → 6'b011111
  - stallreq_ex → 6'b001111
  - stallreq_id or stallreq_if → 6'b000111
  - else 6'b000000
- Done-flag clearing:
  - mem_done clears on the edge where stall[4]==0 (mem_wb captured the result).
  - if_done clears on the edge where stall[1]==0.
  - Set and clear in the same cycle: set wins only if the ack is for a new transaction. Since a done flag blocks a regrant, this cannot occur; assert it in the bench.
- Simultaneous first requests from IF and MEM in IDLE: MEM is granted; IF is stalled by stall[4:0] anyway.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter runs in BUSY_x and resets on every grant.
  - When it reaches TIMEOUT_CYCLES without ack, the transaction completes as if acked with rdata=32'h0.
  - bus_err pulses for 1 cycle and bus_req drops.
- Undefined: no counter; bus_err is tied 0; a missing ack stalls forever.

Test Plan:
- Single fetch: if_ce=1, if_addr=0x00000100, bus_ack after 3 cycles with bus_rdata=0x3C011234 → bus_req high for 3 cycles, stall=000111 until the ack cycle, if_rdata=0x3C011234 in the ack cycle, stall=0 that cycle.
- Load with downstream stall: mem_ce=1, mem_addr=0x80, ack with 0xDEADBEEF, stallreq_ex=1 for 2 more cycles → stall=011111 until ack, then 001111. mem_rdata holds 0xDEADBEEF through both stalled cycles, and no second bus cycle is issued.
- Conflict: if_ce and mem_ce rise together → first bus_addr=mem_addr; the IF bus cycle starts after one IDLE cycle following the MEM ack.
- Store: mem_we=1, sel=4'b0011, wdata=0x0000ABCD → bus_we=1, bus_sel=0011, bus_wdata=0x0000ABCD held stable until ack; mem_rdata unchanged.
- Reset mid-transaction: rst asserted in BUSY_MEM → next cycle bus_req=0, stall=0, a late bus_ack is ignored, mem_rdata=0.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack → bus_err pulses exactly once after 4 busy cycles, mem_rdata=0, and stall releases.
